// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: op encodings, FSM states and divider constants shared by the multiply/divide sequencer
package muldiv_seq_pkg;
    localparam logic [3:0] mult_mc  = 4'b0001;
    localparam logic [3:0] multu_mc = 4'b0010;
    localparam logic [3:0] div_mc   = 4'b0100;
    localparam logic [3:0] divu_mc  = 4'b1000;
    localparam int DIV_ITERS = 32;
    typedef enum logic [1:0] {IDLE, MUL, DIV, DFIX} state_t;
endpackage

// File: rtl/muldiv_seq_div_iter.sv
// div_iter: 32-bit unsigned restoring divider, one quotient bit per edge
module div_iter
    import muldiv_seq_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        cancel,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quot,
    output logic [31:0] rem
);
    logic [5:0]  cnt;
    logic [31:0] dvs;
    logic [32:0] trial;
    assign trial = {rem, quot[31]} - {1'b0, dvs};
    // done marks the cycle whose closing edge performs the final iteration
    assign done = cnt == 6'd1;
    // load operands on start, then shift/subtract until the counter drains
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt  <= '0;
            dvs  <= '0;
            quot <= '0;
            rem  <= '0;
        end else if (cancel) begin
            cnt <= '0;
        end else if (start) begin
            cnt  <= 6'(DIV_ITERS);
            dvs  <= divisor;
            quot <= dividend;
            rem  <= '0;
        end else if (cnt != 6'd0) begin
            cnt  <= cnt - 6'd1;
            quot <= {quot[30:0], ~trial[32]};
            rem  <= trial[32] ? {rem[30:0], quot[31]} : trial[31:0];
        end
    end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multiply/divide sequencer owning HI/LO, with pipeline stall generation
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [3:0]  mul_control,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [1:0]  hilo_wen,
    input  logic [31:0] hilo_wdata,
    input  logic [1:0]  hilo_rd,
    output logic [31:0] hilo_rdata,
    input  logic        flush,
    output logic        busy,
    output logic        stall
);
    state_t      state, state_nx;
    logic [31:0] hi, lo, abs_a, abs_b, quot, rem;
    logic [63:0] ext_a, ext_b;
    logic [63:0] pipe [MUL_LAT];
    logic [7:0]  mcnt;
    logic        accept, is_div, sgn_mul, sgn_div, neg_q, neg_r, div_done, mul_wr, div_wr;

    assign is_div  = |(mul_control & (div_mc | divu_mc));
    assign sgn_mul = |(mul_control & mult_mc);
    assign sgn_div = |(mul_control & div_mc);
    assign ext_a   = {{32{sgn_mul & src_a[31]}}, src_a};
    assign ext_b   = {{32{sgn_mul & src_b[31]}}, src_b};
    assign abs_a   = (sgn_div & src_a[31]) ? -src_a : src_a;
    assign abs_b   = (sgn_div & src_b[31]) ? -src_b : src_b;
    // a flushed issue is dropped: the instruction carrying it is being cancelled
    assign accept  = issue_valid & issue_ready & ~flush;
    assign hilo_rdata = hilo_rd[0] ? hi : lo;

    div_iter u_div (
        .clk      (clk),
        .resetn   (resetn),
        .start    (accept & is_div),
        .cancel   (flush),
        .dividend (abs_a),
        .divisor  (abs_b),
        .done     (div_done),
        .quot     (quot),
        .rem      (rem)
    );

    // state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // next-state: flush always returns to IDLE
    always_comb begin
        state_nx = state;
        if (flush) state_nx = IDLE;
        else begin
            unique case (state)
                IDLE: state_nx = accept ? (is_div ? DIV : MUL) : IDLE;
                MUL:  state_nx = (mcnt == 8'd0) ? IDLE : MUL;
                DIV:  state_nx = div_done ? DFIX : DIV;
                DFIX: state_nx = IDLE;
            endcase
        end
    end

    // handshake, stall and completion strobes
    always_comb begin
        busy        = state != IDLE;
        issue_ready = ~busy;
        stall       = busy & (issue_valid | (|hilo_rd) | (|hilo_wen));
        mul_wr      = (state == MUL) & (mcnt == 8'd0) & ~flush;
        div_wr      = (state == DFIX) & ~flush;
    end

    // sign-fix flags, multiply pipeline and its latency counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mcnt  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            for (int i = 0; i < MUL_LAT; i++) pipe[i] <= '0;
        end else begin
            if (accept) begin
                mcnt    <= 8'(MUL_LAT - 1);
                neg_q   <= sgn_div & (src_a[31] ^ src_b[31]);
                neg_r   <= sgn_div & src_a[31];
                pipe[0] <= ext_a * ext_b;
            end else if (state == MUL && mcnt != 8'd0) begin
                mcnt <= mcnt - 8'd1;
            end
            for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    // HI/LO: completion writes while busy, mthi/mtlo only when idle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else if (mul_wr) begin
            hi <= pipe[MUL_LAT-1][63:32];
            lo <= pipe[MUL_LAT-1][31:0];
        end else if (div_wr) begin
            hi <= neg_r ? -rem : rem;
            lo <= neg_q ? -quot : quot;
        end else if (!busy) begin
            if (hilo_wen[0]) hi <= hilo_wdata;
            if (hilo_wen[1]) lo <= hilo_wdata;
        end
    end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Sequencer for the integer multiply/divide resource and the architectural HI/LO registers. It accepts one `mult`/`multu`/`div`/`divu` operation at a time, selected by the 4-bit `mul_control` from the ALU control decoder. It runs a multi-cycle multiply or a 32-iteration divide, writes HI/LO on completion, and serves `mfhi`/`mflo`/`mthi`/`mtlo`. It stalls the pipeline while any of these would observe an in-flight result.

## Interface
- `MUL_LAT`, 2: edges from issue acceptance to HI/LO write for multiply (≥1).
- `clk  in  1` — single clock.
- `resetn  in  1` — asynchronous, active-low reset.
- `issue_valid  in  1` — `mul_control` carries a valid operation.
- `issue_ready  out  1` — `!busy`. Issue is accepted on an edge where `issue_valid && issue_ready`.
- `mul_control  in  4` — one-hot operation select: bit0 `mult`, bit1 `multu`, bit2 `div`, bit3 `divu`.
- `src_a  in  32` — rs: multiplicand / dividend.
- `src_b  in  32` — rt: multiplier / divisor.
- `hilo_wen  in  2` — bit0 `mthi`, bit1 `mtlo`.
- `hilo_wdata  in  32` — rs value for `mthi`/`mtlo`.
- `hilo_rd  in  2` — bit0 `mfhi`, bit1 `mflo`.
- `hilo_rdata  out  32` — HI if `hilo_rd[0]`, else LO. Combinational from the registers.
- `flush  in  1` — cancels the in-flight operation.
- `busy  out  1` — operation in flight.
- `stall  out  1` — `busy && (issue_valid | |hilo_rd | |hilo_wen)`.

## Operation
- States: IDLE, MUL, DIV, DFIX.
- **IDLE**
  - An accepted issue latches the operands and op. The next state is MUL for multiply ops, DIV for divide ops.
  - `hilo_wen` bits write HI/LO on any non-busy edge.
  - If issue and `hilo_wen` occur on the same edge, both are honoured; the later op completion overwrites HI/LO.
- **MUL**
  - The product is computed as 64-bit signed (`mult`) or unsigned (`multu`) and pipelined through `MUL_LAT` register stages.
  - A down-counter runs from `MUL_LAT-1`.
  - At 0: HI = product[63:32], LO = product[31:0], then go to IDLE.
- **DIV**
  - For `div`, the operands are converted to absolute values. `divu` uses them as-is.
  - The `div_iter` core performs 32 restoring iterations, one per edge, using a 6-bit counter. It then goes to DFIX.
- **DFIX**
  - For `div`: the quotient is negated if `src_a[31]^src_b[31]`; the remainder is negated if `src_a[31]`.
  - LO = quotient, HI = remainder. Then go to IDLE.
- Divide by zero is not trapped; the core produces q = 0xFFFFFFFF and r = |dividend|, followed by the normal sign fixup.
  - `div 0x80000000 / 0xFFFFFFFF` yields LO = 0x80000000, HI = 0.
- `flush`
  - The next state is IDLE and HI/LO are unchanged.
  - `flush` has priority over a completion write on the same edge.
  - It does not block a `hilo_wen` write on a non-busy edge.
- `hilo_rd` with both bits set selects HI.
- Reset: state IDLE; HI = LO = 0; `busy` = 0, `issue_ready` = 1, `stall` = 0, `hilo_rdata` = 0. The divider counter and operand latches are cleared. Reset asserted mid-operation aborts it without a HI/LO write.

## Timing
- Issue accepted on edge E0.
- Multiply: HI/LO written on edge E`MUL_LAT`. `busy` is high from E0 to E`MUL_LAT`.
- Divide: iterations on E1..E32, fixup and write on E33. `busy` is high for 33 cycles.
- A new issue can be accepted on the edge right after completion (back-to-back, one idle cycle minimum).
- Reads stalled behind a busy op see the new value in the first cycle with `busy` = 0.

## Structure
- Shared package/define file holds:
  - `mul_control` one-hot encodings (`mult_mc`, `multu_mc`, `div_mc`, `divu_mc`), shared with the ALU control decoder;
  - state encodings;
  - `DIV_ITERS` = 32.
- One sub-module: `div_iter`.
  - 32-bit unsigned restoring divider with `start`/`done` and a `cancel` input (driven by `flush`).
  - Outputs `quot` and `rem`.
- Sign handling, the multiply pipeline and HI/LO live in `muldiv_seq`.

## Test plan
- `mult 0xFFFFFFFF × 0x00000002`, `MUL_LAT` = 2:
  - HI = 0xFFFFFFFF, LO = 0xFFFFFFFE after E2.
  - `multu` with the same operands gives HI = 0x00000001, LO = 0xFFFFFFFE.
- Divide results and timing:
  - `div 0xFFFFFFF9 / 2` (−7/2) → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF after E33; `busy` high exactly 33 cycles.
  - `divu 100 / 7` → LO = 14, HI = 2.
- `mflo` presented 5 cycles after a `divu 100/7` issue:
  - `stall` = 1 until `busy` drops;
  - in the first non-busy cycle `hilo_rdata` = 14 and `stall` = 0.
- Divide-by-zero and overflow:
  - `divu 0x1234 / 0` → LO = 0xFFFFFFFF, HI = 0x1234.
  - `div 0x80000000 / 0xFFFFFFFF` → LO = 0x80000000, HI = 0.
- Flush and reset mid-operation (HI/LO preloaded via `mthi` 0xA5A5A5A5 / `mtlo` 0x5A5A5A5A):
  - `flush` during iteration 10 → HI/LO unchanged, `issue_ready` = 1 the next cycle.
  - `resetn` low mid-multiply → HI = LO = 0 and `busy` = 0 immediately.
- `mthi` presented while a divide is busy:
  - `stall` = 1 and no write while busy;
  - the write lands on the first non-busy edge;
  - `mfhi` then returns the written value.
